// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshake and RAM port signals for mem_port_arbiter.
// slave = arbiter view, master = requester/RAM side view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [2:0]        Req;
  logic [2:0]        Wr;
  logic [ADDR_W-1:0] Addr0;
  logic [ADDR_W-1:0] Addr1;
  logic [ADDR_W-1:0] Addr2;
  logic [DATA_W-1:0] WData0;
  logic [DATA_W-1:0] WData1;
  logic [DATA_W-1:0] WData2;
  logic [2:0]        Grant;
  logic [2:0]        Done;
  logic [DATA_W-1:0] RData;
  logic              Busy;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic              MemWE;
  logic [DATA_W-1:0] MemRData;

  modport slave (
    input  Req, Wr, Addr0, Addr1, Addr2, WData0, WData1, WData2, MemRData,
    output Grant, Done, RData, Busy, MemAddr, MemWData, MemWE
  );

  modport master (
    output Req, Wr, Addr0, Addr1, Addr2, WData0, WData1, WData2, MemRData,
    input  Grant, Done, RData, Busy, MemAddr, MemWData, MemWE
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among three requesters
// (0 = load/store, 1 = instruction fetch, 2 = display/IO). One transaction
// at a time; per-requester Req/Done handshake; all outputs registered.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input logic                Clk,
  input logic                Reset_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t            r_state;
  logic [1:0]        r_ptr;
  logic [1:0]        r_idx;
  logic              r_wr;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_grant;
  logic [2:0]        r_done;
  logic [DATA_W-1:0] r_rdata;
  logic              r_busy;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;

  logic [1:0]        w_cand0;
  logic [1:0]        w_cand1;
  logic [1:0]        w_cand2;
  logic              w_found;
  logic [1:0]        w_winner;
  logic              w_sel_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    case (i)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Priority scan starting at the round-robin pointer: Ptr, Ptr+1, Ptr+2 (mod 3).
  always_comb begin
    w_cand0  = r_ptr;
    w_cand1  = next_idx(r_ptr);
    w_cand2  = next_idx(w_cand1);
    w_found  = 1'b1;
    w_winner = w_cand0;
    if (bus.Req[w_cand0]) begin
      w_winner = w_cand0;
    end else if (bus.Req[w_cand1]) begin
      w_winner = w_cand1;
    end else if (bus.Req[w_cand2]) begin
      w_winner = w_cand2;
    end else begin
      w_found  = 1'b0;
    end
  end

  // Select the winning requester's command fields for latching.
  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    case (w_winner)
      2'd0: begin
        w_sel_wr    = bus.Wr[0];
        w_sel_addr  = bus.Addr0;
        w_sel_wdata = bus.WData0;
      end
      2'd1: begin
        w_sel_wr    = bus.Wr[1];
        w_sel_addr  = bus.Addr1;
        w_sel_wdata = bus.WData1;
      end
      default: begin
        w_sel_wr    = bus.Wr[2];
        w_sel_addr  = bus.Addr2;
        w_sel_wdata = bus.WData2;
      end
    endcase
  end

  // Transaction FSM; every output is a register updated alongside the state.
  // MemAddr/MemWData registers double as the latched copy of the owner's command.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_wr        <= 1'b0;
      r_cnt       <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_idx       <= w_winner;
            r_wr        <= w_sel_wr;
            r_ptr       <= next_idx(w_winner);
            r_grant     <= onehot(w_winner);
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_we    <= w_sel_wr;
            r_busy      <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_mem_we <= 1'b0;
          if (r_wr) begin
            r_done  <= onehot(r_idx);
            r_state <= ST_DONE;
          end else begin
            r_cnt   <= CNT_W'(RD_LAT - 1);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_rdata <= bus.MemRData;
            r_done  <= onehot(r_idx);
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.Grant    = r_grant;
  assign bus.Done     = r_done;
  assign bus.RData    = r_rdata;
  assign bus.Busy     = r_busy;
  assign bus.MemAddr  = r_mem_addr;
  assign bus.MemWData = r_mem_wdata;
  assign bus.MemWE    = r_mem_we;

  // Structural invariants of the handshake.
  a_grant_onehot0: assert property (@(posedge Clk) disable iff (!Reset_n)
    $onehot0(r_grant));
  a_done_onehot0: assert property (@(posedge Clk) disable iff (!Reset_n)
    $onehot0(r_done));
  a_done_matches_grant: assert property (@(posedge Clk) disable iff (!Reset_n)
    (r_done != '0) |-> (r_done == r_grant));
  a_we_only_in_issue: assert property (@(posedge Clk) disable iff (!Reset_n)
    r_mem_we |-> (r_state == ST_ISSUE));

endmodule
